// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, R-type functs
// and the MULTU sequencer state type.
package cpu_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_MULTU = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } multu_state_t;

  // Retire width must be a small power of two that tiles the operand.
  function automatic bit bpc_ok(input int w, input int k);
    return (k == 1 || k == 2 || k == 4 || k == 8)
        && (k < w) && (w % k == 0);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: upper half plus mcand times a
// k-bit multiplier chunk, kept wide enough for the carry.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0]   acc_upper,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [K-1:0]       chunk,
  output logic [WIDTH+K-1:0] sum
);

  localparam int SW = WIDTH + K;

  assign sum = SW'(acc_upper) + SW'(mcand) * SW'(chunk);

endmodule

// File: rtl/multu_unit.sv
// Iterative unsigned multiplier with HI/LO result registers;
// stalls the pipeline while the product is formed.
module multu_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int ITERS = WIDTH / K;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  generate
    if (!bpc_ok(WIDTH, K)) begin : g_bad_bpc
      $error("multu_unit: illegal BITS_PER_CYCLE");
    end
  endgenerate

  multu_state_t         state;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH+K-1:0]   upper;

  mul_step #(
    .WIDTH (WIDTH),
    .K     (K)
  ) u_step (
    .acc_upper (acc[2*WIDTH-1:WIDTH]),
    .mcand     (mcand),
    .chunk     (acc[K-1:0]),
    .sum       (upper)
  );

  // Consumed multiplier bits fall off the bottom as the sum enters the top.
  assign acc_nxt = {upper, acc[WIDTH-1:K]};

  assign stall = ((state == IDLE) && start) || busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            hi    <= acc_nxt[2*WIDTH-1:WIDTH];
            lo    <= acc_nxt[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        // The MULTU is still being decoded here; never retrigger.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_unit.sv
// Directed and random checks of multu_unit against a plain
// 64-bit product model, at 1 and 4 bits per cycle.
module tb_multu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [31:0] a, b, a4, b4;
  logic        stall, busy, done;
  logic        stall4, busy4, done4;
  logic [31:0] hi, lo, hi4, lo4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multu_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  multu_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .stall (stall4),
    .busy  (busy4),
    .done  (done4),
    .hi    (hi4),
    .lo    (lo4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel=0 drives the 1-bit unit, sel=1 the 4-bit unit.
  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     input bit hold, input bit sel);
    logic [63:0] p;
    int n;
    int lat;
    bit seen;
    p   = {32'b0, x} * {32'b0, y};
    lat = sel ? 9 : 33;
    if (sel) begin a4 = x; b4 = y; start4 = 1'b1; end
    else begin a = x; b = y; start = 1'b1; end
    #1;
    chk("stall_issue", sel ? stall4 : stall, 1);
    tick();
    n = 1;
    seen = 0;
    if (!hold) begin start = 1'b0; start4 = 1'b0; end
    while (n < 100 && !seen) begin
      if (sel ? done4 : done) seen = 1;
      else begin
        chk("stall_run", sel ? stall4 : stall, 1);
        chk("busy_run", sel ? busy4 : busy, 1);
        tick();
        n++;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", n, lat);
    chk("stall_done", sel ? stall4 : stall, 0);
    chk("busy_done", sel ? busy4 : busy, 0);
    chk("hi", sel ? hi4 : hi, p[63:32]);
    chk("lo", sel ? lo4 : lo, p[31:0]);
    tick();
    start = 1'b0;
    start4 = 1'b0;
    chk("done_pulse", sel ? done4 : done, 0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 0);
        chk("hold_hi", hi, p[63:32]);
        chk("hold_lo", lo, p[31:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst4_busy", busy4, 0);

    run(32'd3, 32'd5, 0, 0);
    chk("small_hi", hi, 64'h0);
    chk("small_lo", lo, 64'hF);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("max_hi", hi, 64'hFFFF_FFFE);
    chk("max_lo", lo, 64'h1);
    run(32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
    chk("mix_hi", hi, 64'h0B00_EA4E);
    chk("mix_lo", lo, 64'h242D_2080);

    // Abort an operation with reset at cycle 10.
    run(32'd3, 32'd5, 0, 0);
    a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
        if (done || busy) dn++;
        tick();
      end
      chk("abort_quiet", dn, 0);
    end

    run(32'd0, 32'hDEAD_BEEF, 0, 0);
    chk("zero_hi", hi, 0);
    chk("zero_lo", lo, 0);
    run(32'hDEAD_BEEF, 32'd1, 0, 0);
    chk("one_hi", hi, 0);
    chk("one_lo", lo, 64'hDEAD_BEEF);

    for (int i = 0; i < 6; i++) run($urandom, $urandom, 0, 0);

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    chk("max4_hi", hi4, 64'hFFFF_FFFE);
    chk("max4_lo", lo4, 64'h1);
    for (int i = 0; i < 4; i++) run($urandom, $urandom, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
